priority_resolver_isr: RTL and testbench

PRIORITY_RESOLVER_ISR -- requirements
Module: priority_resolver_isr

---
 rtl/priority_resolver_isr.sv | 172 +++++++++++++++++
 tb/tb_priority_resolver_isr.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_isr.sv
`default_nettype none
// ============================================================================
// Module      : priority_resolver_isr
// Description : 8259-style priority resolver and in-service register.
//               Picks the highest-priority pending request under a rotating
//               priority order, runs the two-INTA acknowledge handshake and
//               services specific, non-specific and automatic EOI.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_resolver_isr #(
    parameter logic [2:0] LOWEST_INIT = 3'd7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] risedBits,
    input  logic       INTA,
    input  logic       nonSpecificEOI,
    input  logic       specificEOI,
    input  logic [2:0] eoiLevel,
    input  logic       autoEOI,
    input  logic       rotateOnEOI,
    input  logic       readISR,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic       vectorValid,
    output logic [2:0] vectorOut,
    output logic [7:0] ISR,
    output logic [7:0] dataBuffer
);

    localparam logic [0:0] c_IDLE       = 1'b0;
    localparam logic [0:0] c_ACK2       = 1'b1;
    localparam logic [2:0] c_SPURIOUS   = 3'd7;

    logic [0:0] r_state;
    logic [2:0] r_lowestPriority;
    logic [7:0] r_isr;
    logic       r_int;
    logic [2:0] r_level;
    logic       r_serviced;
    logic       r_readPriority;
    logic [2:0] r_resetIRR;
    logic       r_vectorValid;
    logic [2:0] r_vectorOut;

    logic [7:0] w_reqRot;
    logic [7:0] w_isrRot;
    logic [2:0] w_reqRank;
    logic [2:0] w_isrRank;
    logic       w_reqAny;
    logic       w_isrAny;
    logic [2:0] w_winner;
    logic [2:0] w_isrTop;
    logic       w_eligible;
    logic       w_service;
    logic       w_eoiHit;
    logic [2:0] w_eoiLevel;
    logic       w_aeoiHit;
    logic [7:0] w_clearMask;
    logic [7:0] w_setMask;

    // Rotate requests and ISR so that bit 0 is the current highest-priority level.
    always_comb begin
        w_reqRot = 8'd0;
        w_isrRot = 8'd0;
        for (int k = 0; k < 8; k++) begin
            w_reqRot[k] = risedBits[r_lowestPriority + 3'd1 + 3'(k)];
            w_isrRot[k] = r_isr[r_lowestPriority + 3'd1 + 3'(k)];
        end
    end

    // Find the rank (0 = highest) of the best pending request and best in-service bit.
    always_comb begin
        w_reqRank = 3'd0;
        w_isrRank = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_reqRot[k]) w_reqRank = 3'(k);
            if (w_isrRot[k]) w_isrRank = 3'(k);
        end
    end

    assign w_reqAny   = |risedBits;
    assign w_isrAny   = |r_isr;
    assign w_winner   = r_lowestPriority + 3'd1 + w_reqRank;
    assign w_isrTop   = r_lowestPriority + 3'd1 + w_isrRank;
    // Fully nested: a request must strictly outrank every level already in service.
    assign w_eligible = w_reqAny && (!w_isrAny || (w_reqRank < w_isrRank));
    // A request that vanished between INT and INTA is treated like a spurious INTA.
    assign w_service  = (r_state == c_IDLE) && INTA && r_int && w_eligible;

    // Decode which ISR bit (if any) an EOI command clears; specific EOI has precedence.
    always_comb begin
        w_eoiHit   = 1'b0;
        w_eoiLevel = eoiLevel;
        if (specificEOI) begin
            w_eoiLevel = eoiLevel;
            w_eoiHit   = r_isr[eoiLevel];
        end else if (nonSpecificEOI) begin
            w_eoiLevel = w_isrTop;
            w_eoiHit   = w_isrAny;
        end
    end

    assign w_aeoiHit   = (r_state == c_ACK2) && INTA && autoEOI && r_serviced && r_isr[r_level];
    assign w_clearMask = (w_eoiHit  ? (8'd1 << w_eoiLevel) : 8'd0)
                       | (w_aeoiHit ? (8'd1 << r_level)    : 8'd0);
    assign w_setMask   = w_service ? (8'd1 << w_winner) : 8'd0;

    // Acknowledge FSM, ISR update, priority rotation and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_lowestPriority <= LOWEST_INIT;
            r_isr            <= 8'd0;
            r_int            <= 1'b0;
            r_level          <= 3'd0;
            r_serviced       <= 1'b0;
            r_readPriority   <= 1'b0;
            r_resetIRR       <= 3'd0;
            r_vectorValid    <= 1'b0;
            r_vectorOut      <= 3'd0;
        end else begin
            // Clear uses the pre-edge ISR; a set of the same bit overrides the clear.
            r_isr          <= (r_isr & ~w_clearMask) | w_setMask;
            r_readPriority <= 1'b0;
            r_vectorValid  <= 1'b0;
            r_int          <= 1'b0;
            if (rotateOnEOI) begin
                if (w_aeoiHit) begin
                    r_lowestPriority <= r_level;
                end else if (w_eoiHit) begin
                    r_lowestPriority <= w_eoiLevel;
                end
            end
            case (r_state)
                c_IDLE: begin
                    r_int <= !INTA && w_eligible;
                    if (INTA) begin
                        r_state <= c_ACK2;
                        if (w_service) begin
                            r_level        <= w_winner;
                            r_serviced     <= 1'b1;
                            r_readPriority <= 1'b1;
                            r_resetIRR     <= w_winner;
                        end else begin
                            r_level    <= c_SPURIOUS;
                            r_serviced <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (INTA) begin
                        r_vectorValid <= 1'b1;
                        r_vectorOut   <= r_level;
                        r_state       <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign INT          = r_int;
    assign readPriority = r_readPriority;
    assign resetIRR     = r_resetIRR;
    assign vectorValid  = r_vectorValid;
    assign vectorOut    = r_vectorOut;
    assign ISR          = r_isr;
    assign dataBuffer   = readISR ? r_isr : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_priority_resolver_isr.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_resolver_isr
// Description : Scoreboard bench for priority_resolver_isr. A level-based
//               reference model predicts each cycle's outputs; a monitor
//               compares them one cycle at a time. Directed scenarios are
//               followed by a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_resolver_isr;

    typedef struct {
        logic       intv;
        logic [7:0] isr;
        logic       rp;
        logic [2:0] rpl;
        logic       vv;
        logic [2:0] vvl;
        logic [7:0] db;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] risedBits;
    logic       INTA;
    logic       nonSpecificEOI;
    logic       specificEOI;
    logic [2:0] eoiLevel;
    logic       autoEOI;
    logic       rotateOnEOI;
    logic       readISR;
    logic       INT;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic       vectorValid;
    logic [2:0] vectorOut;
    logic [7:0] ISR;
    logic [7:0] dataBuffer;

    int   nChecks = 0;
    int   nFails  = 0;
    exp_t sb[$];
    exp_t mon;

    // Reference model state (reset values)
    logic [7:0] mIsr     = 8'd0;
    int         mLow     = 7;
    bit         mAck2    = 1'b0;
    int         mLevel   = 0;
    bit         mServiced = 1'b0;
    bit         mInt     = 1'b0;
    logic [7:0] irr      = 8'd0;

    priority_resolver_isr #(.LOWEST_INIT(3'd7)) dut (
        .clk            (clk),
        .reset          (reset),
        .risedBits      (risedBits),
        .INTA           (INTA),
        .nonSpecificEOI (nonSpecificEOI),
        .specificEOI    (specificEOI),
        .eoiLevel       (eoiLevel),
        .autoEOI        (autoEOI),
        .rotateOnEOI    (rotateOnEOI),
        .readISR        (readISR),
        .INT            (INT),
        .readPriority   (readPriority),
        .resetIRR       (resetIRR),
        .vectorValid    (vectorValid),
        .vectorOut      (vectorOut),
        .ISR            (ISR),
        .dataBuffer     (dataBuffer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Rank of a level under a given lowest level: 0 = highest, 7 = lowest.
    function automatic int prioRank(input int level, input int low);
        return (level - low + 8 + 7) % 8;
    endfunction

    // Highest-priority set level of a vector, or -1 when empty.
    function automatic int bestLevel(input logic [7:0] bits, input int low);
        int best = -1;
        for (int lvl = 0; lvl < 8; lvl++) begin
            if (bits[lvl] && (best < 0 || prioRank(lvl, low) < prioRank(best, low))) best = lvl;
        end
        return best;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic modelTick(output bit rpOut, output int rpLvl);
        exp_t       e;
        int         w, top, eoiLvl;
        bit         elig, eoiHit, aeoiHit;
        logic [7:0] nIsr;
        rpOut = 1'b0;
        rpLvl = 0;
        e.intv = 1'b0; e.isr = 8'd0; e.rp = 1'b0; e.rpl = 3'd0;
        e.vv = 1'b0; e.vvl = 3'd0; e.db = 8'd0;
        if (reset) begin
            mIsr = 8'd0; mLow = 7; mAck2 = 1'b0; mLevel = 0; mServiced = 1'b0; mInt = 1'b0;
        end else begin
            w    = bestLevel(risedBits, mLow);
            top  = bestLevel(mIsr, mLow);
            elig = (w >= 0) && (top < 0 || prioRank(w, mLow) < prioRank(top, mLow));
            eoiHit = 1'b0;
            eoiLvl = 0;
            if (specificEOI) begin
                eoiLvl = int'(eoiLevel);
                eoiHit = mIsr[eoiLevel];
            end else if (nonSpecificEOI && top >= 0) begin
                eoiLvl = top;
                eoiHit = 1'b1;
            end
            aeoiHit = mAck2 && INTA && autoEOI && mServiced && mIsr[mLevel];
            nIsr = mIsr;
            if (eoiHit)  nIsr[eoiLvl] = 1'b0;
            if (aeoiHit) nIsr[mLevel] = 1'b0;
            if (rotateOnEOI) begin
                if (aeoiHit) mLow = mLevel;
                else if (eoiHit) mLow = eoiLvl;
            end
            if (!mAck2) begin
                e.intv = !INTA && elig;
                if (INTA) begin
                    mAck2 = 1'b1;
                    if (mInt && elig) begin
                        nIsr[w] = 1'b1;
                        mLevel = w; mServiced = 1'b1;
                        e.rp = 1'b1; e.rpl = 3'(w);
                        rpOut = 1'b1; rpLvl = w;
                    end else begin
                        mLevel = 7; mServiced = 1'b0;
                    end
                end
            end else begin
                e.intv = 1'b0;
                if (INTA) begin
                    e.vv = 1'b1; e.vvl = 3'(mLevel);
                    mAck2 = 1'b0;
                end
            end
            mIsr  = nIsr;
            mInt  = e.intv;
            e.isr = nIsr;
            e.db  = readISR ? nIsr : 8'h00;
        end
        sb.push_back(e);
    endtask

    // Push the prediction for the coming edge, then wait for the next negedge.
    task automatic tick();
        bit rp;
        int lvl;
        modelTick(rp, lvl);
        if (rp) irr[lvl] = 1'b0;
        @(negedge clk);
    endtask

    task automatic idleInputs();
        reset = 1'b0; INTA = 1'b0; nonSpecificEOI = 1'b0; specificEOI = 1'b0;
        eoiLevel = 3'd0; autoEOI = 1'b0; rotateOnEOI = 1'b0; readISR = 1'b0;
    endtask

    // Monitor: after every active edge compare DUT outputs with the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                mon = sb.pop_front();
                chk("INT", 8'(INT), 8'(mon.intv));
                chk("ISR", ISR, mon.isr);
                chk("readPriority", 8'(readPriority), 8'(mon.rp));
                if (mon.rp) chk("resetIRR", 8'(resetIRR), 8'(mon.rpl));
                chk("vectorValid", 8'(vectorValid), 8'(mon.vv));
                if (mon.vv) chk("vectorOut", 8'(vectorOut), 8'(mon.vvl));
                chk("dataBuffer", dataBuffer, mon.db);
            end
        end
    end

    // Stimulus: reset, directed scenarios, then randomized traffic.
    initial begin
        idleInputs();
        reset = 1'b1;
        risedBits = 8'd0;
        @(negedge clk);
        tick();
        tick();
        chk("rst ISR", ISR, 8'h00);
        chk("rst INT", 8'(INT), 8'h00);
        chk("rst readPriority", 8'(readPriority), 8'h00);
        chk("rst resetIRR", 8'(resetIRR), 8'h00);
        chk("rst vectorValid", 8'(vectorValid), 8'h00);
        chk("rst vectorOut", 8'(vectorOut), 8'h00);
        reset = 1'b0;

        // Nested service: IR2 wins, IR5 blocked while IR2 in service
        risedBits = 8'b0010_0100; tick();
        chk("n1 INT", 8'(INT), 8'h01);
        INTA = 1'b1; tick();
        chk("n1 resetIRR", 8'(resetIRR), 8'h02);
        chk("n1 ISR", ISR, 8'h04);
        risedBits = 8'h20; tick();
        chk("n1 vectorOut", 8'(vectorOut), 8'h02);
        INTA = 1'b0; tick();
        chk("n1 IR5 blocked", 8'(INT), 8'h00);

        // Non-specific EOI releases IR5
        nonSpecificEOI = 1'b1; tick();
        chk("n2 ISR cleared", ISR, 8'h00);
        nonSpecificEOI = 1'b0; tick();
        chk("n2 INT", 8'(INT), 8'h01);
        INTA = 1'b1; tick();
        risedBits = 8'h00; tick();
        chk("n2 ISR", ISR, 8'h20);
        INTA = 1'b0; nonSpecificEOI = 1'b1; tick();
        nonSpecificEOI = 1'b0;

        // Specific EOI with rotation makes IR3 lowest, so IR4 beats IR0
        risedBits = 8'h08; tick();
        INTA = 1'b1; tick();
        risedBits = 8'h00; tick();
        INTA = 1'b0;
        chk("r ISR set", ISR, 8'h08);
        rotateOnEOI = 1'b1; specificEOI = 1'b1; eoiLevel = 3'd3; tick();
        chk("r ISR cleared", ISR, 8'h00);
        rotateOnEOI = 1'b0; specificEOI = 1'b0;
        risedBits = 8'h11; tick();
        INTA = 1'b1; tick();
        chk("r winner", 8'(resetIRR), 8'h04);
        risedBits = 8'h01; tick();
        INTA = 1'b0; risedBits = 8'h00; nonSpecificEOI = 1'b1; tick();
        nonSpecificEOI = 1'b0;

        // Automatic EOI
        autoEOI = 1'b1; risedBits = 8'h80; tick();
        INTA = 1'b1; tick();
        chk("a ISR between", ISR, 8'h80);
        risedBits = 8'h00; tick();
        chk("a vectorOut", 8'(vectorOut), 8'h07);
        chk("a ISR after", ISR, 8'h00);
        INTA = 1'b0; autoEOI = 1'b0; tick();

        // Spurious INTA
        INTA = 1'b1; tick();
        chk("s readPriority", 8'(readPriority), 8'h00);
        chk("s ISR", ISR, 8'h00);
        tick();
        chk("s vectorOut", 8'(vectorOut), 8'h07);
        INTA = 1'b0; tick();

        // Reset between INTAs aborts the handshake
        risedBits = 8'h02; tick();
        INTA = 1'b1; tick();
        chk("x ISR set", ISR, 8'h02);
        reset = 1'b1; tick();
        chk("x vectorValid", 8'(vectorValid), 8'h00);
        chk("x ISR", ISR, 8'h00);
        chk("x INT", 8'(INT), 8'h00);
        reset = 1'b0; INTA = 1'b0; risedBits = 8'h00; readISR = 1'b1; tick();
        chk("x dataBuffer", dataBuffer, 8'h00);
        readISR = 1'b0;

        // Randomized traffic
        irr = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            idleInputs();
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) irr[$urandom_range(0, 7)] = 1'b1;
            risedBits = irr;
            if (mAck2)     INTA = ($urandom_range(0, 2) == 0);
            else if (mInt) INTA = ($urandom_range(0, 1) == 0);
            else           INTA = ($urandom_range(0, 39) == 0);
            if (!INTA) begin
                nonSpecificEOI = ($urandom_range(0, 7) == 0);
                specificEOI    = ($urandom_range(0, 7) == 0);
            end
            eoiLevel    = 3'($urandom_range(0, 7));
            autoEOI     = ($urandom_range(0, 3) == 0);
            rotateOnEOI = ($urandom_range(0, 1) == 0);
            readISR     = ($urandom_range(0, 1) == 0);
            tick();
        end

        idleInputs();
        risedBits = 8'h00;
        tick();
        @(posedge clk);
        #2;
        chk("scoreboard drained", 8'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
